write_queue: RTL and testbench
==============================

WRITE_QUEUE -- requirements
Module: write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port alu_valid, input, 1 bit: ALU result request.
REQ-005 SHALL have ports alu_pa_rd, alu_d and alu_context, inputs, `LEN_PREG_ADDR / `LEN_WORD / `LEN_CONTEXT bits: ALU destination, data and context.
REQ-006 SHALL have port alu_ready, output, 1 bit: the ALU request is accepted this cycle.
REQ-007 SHALL have ports mem_valid, mem_pa_rd, mem_d and mem_context (same widths as the ALU ports) and mem_ready: load-result request.
REQ-008 SHALL have port branch_hazard, input, 1 bit, and port hazard_context_info, input, `LEN_CONTEXT bits: the misprediction kill mask, with the same meaning as in reg_manage.
REQ-009 SHALL have port w_write_d_r, output, `LEN_WRITE_D_R bits: packed {w_order, w_pa_rd, w_d_rd} driven to reg_manage.

Function
REQ-010 SHALL hold up to DEPTH entries of {pa_rd, data, context, live}, managed with head and tail pointers plus a count register of width clog2(DEPTH)+1.
REQ-011 SHALL derive mem_ready and alu_ready from the registered count only (no combinational path from any valid input):
  - mem_ready = count <= DEPTH-1;
  - alu_ready = count <= DEPTH-2, or (count == DEPTH-1 and not mem_valid).
REQ-012 SHALL enqueue the mem request before the ALU request when both are accepted in the same cycle; the tail advances by the number accepted.
REQ-013 SHALL drop any request with pa_rd == 0 at acceptance: ready is still high, and no entry is written.
REQ-014 SHALL pop the head entry every cycle the queue is non-empty, because the write stage always consumes.
REQ-015 SHALL drive the output as follows:
  - popped entry: w_order = live, w_pa_rd = entry pa_rd, w_d_rd = entry data;
  - queue empty: w_order = 0, other fields 0.
REQ-016 SHALL, without bypass, give a latency of 1 cycle from request acceptance to w_order for the oldest entry.
REQ-017 SHALL, when branch_hazard = 1, clear live on every stored entry whose (context & hazard_context_info) is nonzero, in the same cycle.
REQ-018 SHALL enqueue an incoming request in the same hazard cycle with live = 0 if its context overlaps the mask.
REQ-019 SHALL never kill an entry whose context is `CONTEXT_ZERO.
REQ-020 SHALL leave killed entries occupying their slot; they pop in order and produce w_order = 0.
REQ-021 SHALL, on a simultaneous pop and enqueue, update count to count - 1 + accepted; count never exceeds DEPTH and never goes below 0.
REQ-022 SHALL let pointers wrap modulo DEPTH.

Reset
REQ-023 SHALL, while rstn = 0, asynchronously clear count, head, tail and all live bits.
REQ-024 SHALL, while rstn = 0, drive w_write_d_r to all zeros and both ready outputs high.
REQ-025 SHALL drop requests presented during reset.
REQ-026 SHALL discard all queued entries when reset is asserted mid-operation, with no partial writes afterward.

Configuration
REQ-027 SHALL, when WRITE_QUEUE_BYPASS_EN is defined, forward a live request straight to w_write_d_r in the same cycle, without storing it, when count == 0 (mem is forwarded first; ALU is forwarded only if mem_valid = 0, otherwise ALU is enqueued).
REQ-028 SHALL, when WRITE_QUEUE_BYPASS_EN is undefined, give every accepted request the latency of REQ-016.

Structure
REQ-029 SHALL take `LEN_PREG_ADDR, `LEN_WORD, `LEN_CONTEXT, `LEN_WRITE_D_R and `CONTEXT_ZERO from the shared include.vh, adding no new global constants.
REQ-030 SHALL build the output with the existing pack_struct_write_d_r.
REQ-031 SHALL contain one sub-module, write_queue_arb, which computes the ready signals, enqueue ordering and tail increments from count and the valid inputs.

Verification
REQ-032 Single ALU request (pa_rd=5, d=0x1234, context=0) into an empty queue -> next cycle w_order=1, w_pa_rd=5, w_d_rd=0x1234; queue empty the cycle after.
REQ-033 Both valid with count=0 (mem pa_rd=3 d=0xA, ALU pa_rd=4 d=0xB) -> both ready; writes pa 3 then pa 4 on consecutive cycles.
REQ-034 Fill to DEPTH=4 with the write port always popping, then present both requests at count=3 -> mem_ready=1, alu_ready=0; count stays at most 4; every accepted entry is written exactly once, in order.
REQ-035 Queue entries with contexts 0b01, 0b10, 0b00, then branch_hazard with mask 0b10 -> outputs w_order = 1, 0, 1 in order.
REQ-036 Assert rstn=0 with 3 entries queued, then release -> w_order=0 until a new request; the first write is the new request only.
REQ-037 With WRITE_QUEUE_BYPASS_EN defined and the queue empty, ALU request pa_rd=7 -> w_order=1, w_pa_rd=7 in the same cycle; count stays 0.

Source files
------------

// File: rtl/write_queue_pkg.sv
// write_queue_pkg: shared widths, the write-port record and its packer, and
// the misprediction kill test used by the write queue.
// These constants reproduce the shared include definitions (LEN_PREG_ADDR,
// LEN_WORD, LEN_CONTEXT, LEN_WRITE_D_R, CONTEXT_ZERO) so this slice builds standalone.
package write_queue_pkg;

    localparam int LEN_PREG_ADDR = 6;
    localparam int LEN_WORD      = 32;
    localparam int LEN_CONTEXT   = 4;
    localparam int LEN_WRITE_D_R = 1 + LEN_PREG_ADDR + LEN_WORD;

    localparam logic [LEN_CONTEXT-1:0] CONTEXT_ZERO = {LEN_CONTEXT{1'b0}};

    // Record handed to reg_manage: {w_order, w_pa_rd, w_d_rd}.
    typedef struct packed {
        logic                     w_order;
        logic [LEN_PREG_ADDR-1:0] w_pa_rd;
        logic [LEN_WORD-1:0]      w_d_rd;
    } write_d_r_t;

    function automatic logic [LEN_WRITE_D_R-1:0] pack_struct_write_d_r(
        input logic                     w_order,
        input logic [LEN_PREG_ADDR-1:0] w_pa_rd,
        input logic [LEN_WORD-1:0]      w_d_rd
    );
        write_d_r_t rec;
        rec.w_order = w_order;
        rec.w_pa_rd = w_pa_rd;
        rec.w_d_rd  = w_d_rd;
        return rec;
    endfunction

    // An entry dies on a hazard when its context overlaps the kill mask;
    // the always-valid context CONTEXT_ZERO can never be killed.
    function automatic logic context_killed(
        input logic [LEN_CONTEXT-1:0] ctx,
        input logic                   hazard,
        input logic [LEN_CONTEXT-1:0] mask
    );
        return hazard && (ctx != CONTEXT_ZERO) && ((ctx & mask) != CONTEXT_ZERO);
    endfunction

endpackage

// File: rtl/write_queue_arb.sv
// write_queue_arb: ready generation from the queue count, mem-before-ALU
// slot ordering and tail increment for one cycle of requests.
module write_queue_arb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic [CNT_W-1:0] count,
    input  logic             mem_valid,
    input  logic             alu_valid,
    input  logic             mem_store,
    input  logic             alu_store,
    output logic             mem_ready,
    output logic             alu_ready,
    output logic             mem_wr,
    output logic             alu_wr,
    output logic             alu_off,
    output logic [1:0]       tail_inc
);

    // Readiness and slot allocation; the ALU takes the slot after mem when both write.
    always_comb begin
        mem_ready = (count <= CNT_W'(DEPTH - 1));
        alu_ready = (count <= CNT_W'(DEPTH - 2)) ||
                    ((count == CNT_W'(DEPTH - 1)) && !mem_valid);
        mem_wr    = mem_valid && mem_ready && mem_store;
        alu_wr    = alu_valid && alu_ready && alu_store;
        alu_off   = mem_wr;
        tail_inc  = {1'b0, mem_wr} + {1'b0, alu_wr};
    end

endmodule

// File: rtl/write_queue.sv
// write_queue: merges ALU and load results into the single register write
// port, with misprediction kill of queued entries.
// Optional feature macro: WRITE_QUEUE_BYPASS_EN forwards a live request
// straight to the write port when the queue is empty.
module write_queue
    import write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     alu_valid,
    input  logic [LEN_PREG_ADDR-1:0] alu_pa_rd,
    input  logic [LEN_WORD-1:0]      alu_d,
    input  logic [LEN_CONTEXT-1:0]   alu_context,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [LEN_PREG_ADDR-1:0] mem_pa_rd,
    input  logic [LEN_WORD-1:0]      mem_d,
    input  logic [LEN_CONTEXT-1:0]   mem_context,
    output logic                     mem_ready,
    input  logic                     branch_hazard,
    input  logic [LEN_CONTEXT-1:0]   hazard_context_info,
    output logic [LEN_WRITE_D_R-1:0] w_write_d_r
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LEN_PREG_ADDR-1:0] PREG_ZERO = {LEN_PREG_ADDR{1'b0}};

    logic [LEN_PREG_ADDR-1:0] pa_r   [DEPTH];
    logic [LEN_WORD-1:0]      data_r [DEPTH];
    logic [LEN_CONTEXT-1:0]   ctx_r  [DEPTH];
    logic [DEPTH-1:0]         live_r;
    logic [PTR_W-1:0]         head_r;
    logic [PTR_W-1:0]         tail_r;
    logic [CNT_W-1:0]         count_r;

    logic             pop_s;
    logic             mem_kill_s;
    logic             alu_kill_s;
    logic             mem_fwd_s;
    logic             alu_fwd_s;
    logic             mem_store_s;
    logic             alu_store_s;
    logic             mem_wr_s;
    logic             alu_wr_s;
    logic             alu_off_s;
    logic [1:0]       tail_inc_s;
    logic [PTR_W-1:0] alu_idx_s;

    assign pop_s      = (count_r != {CNT_W{1'b0}});
    assign mem_kill_s = context_killed(mem_context, branch_hazard, hazard_context_info);
    assign alu_kill_s = context_killed(alu_context, branch_hazard, hazard_context_info);
    assign alu_idx_s  = tail_r + PTR_W'(alu_off_s);

`ifdef WRITE_QUEUE_BYPASS_EN
    // Empty queue: a live request goes straight out; mem wins, ALU only when mem is idle.
    always_comb begin
        mem_fwd_s = !pop_s && mem_valid && (mem_pa_rd != PREG_ZERO) && !mem_kill_s;
        alu_fwd_s = !pop_s && alu_valid && (alu_pa_rd != PREG_ZERO) && !alu_kill_s &&
                    !mem_valid;
    end
`else
    // No forwarding path: every request goes through the queue.
    always_comb begin
        mem_fwd_s = 1'b0;
        alu_fwd_s = 1'b0;
    end
`endif

    // A request takes a slot unless it targets p0 (dropped) or was forwarded.
    always_comb begin
        mem_store_s = (mem_pa_rd != PREG_ZERO) && !mem_fwd_s;
        alu_store_s = (alu_pa_rd != PREG_ZERO) && !alu_fwd_s;
    end

    write_queue_arb #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_arb (
        .count     (count_r),
        .mem_valid (mem_valid),
        .alu_valid (alu_valid),
        .mem_store (mem_store_s),
        .alu_store (alu_store_s),
        .mem_ready (mem_ready),
        .alu_ready (alu_ready),
        .mem_wr    (mem_wr_s),
        .alu_wr    (alu_wr_s),
        .alu_off   (alu_off_s),
        .tail_inc  (tail_inc_s)
    );

    // Write port: head entry when non-empty (masked by a same-cycle kill), else forward, else idle.
    always_comb begin
        if (!rstn) begin
            w_write_d_r = {LEN_WRITE_D_R{1'b0}};
        end else if (pop_s) begin
            w_write_d_r = pack_struct_write_d_r(
                live_r[head_r] &&
                !context_killed(ctx_r[head_r], branch_hazard, hazard_context_info),
                pa_r[head_r], data_r[head_r]);
        end else if (mem_fwd_s) begin
            w_write_d_r = pack_struct_write_d_r(1'b1, mem_pa_rd, mem_d);
        end else if (alu_fwd_s) begin
            w_write_d_r = pack_struct_write_d_r(1'b1, alu_pa_rd, alu_d);
        end else begin
            w_write_d_r = {LEN_WRITE_D_R{1'b0}};
        end
    end

    // Queue state: kill matching entries, enqueue mem then ALU, pop head, move pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pa_r[i]   <= PREG_ZERO;
                data_r[i] <= {LEN_WORD{1'b0}};
                ctx_r[i]  <= CONTEXT_ZERO;
            end
            live_r  <= {DEPTH{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (context_killed(ctx_r[i], branch_hazard, hazard_context_info)) begin
                    live_r[i] <= 1'b0;
                end
            end
            if (mem_wr_s) begin
                pa_r[tail_r]   <= mem_pa_rd;
                data_r[tail_r] <= mem_d;
                ctx_r[tail_r]  <= mem_context;
                live_r[tail_r] <= !mem_kill_s;
            end
            if (alu_wr_s) begin
                pa_r[alu_idx_s]   <= alu_pa_rd;
                data_r[alu_idx_s] <= alu_d;
                ctx_r[alu_idx_s]  <= alu_context;
                live_r[alu_idx_s] <= !alu_kill_s;
            end
            tail_r  <= tail_r + PTR_W'(tail_inc_s);
            head_r  <= head_r + PTR_W'(pop_s);
            count_r <= count_r - CNT_W'(pop_s) + CNT_W'(tail_inc_s);
        end
    end

endmodule

// File: tb/tb_write_queue.sv
// tb_write_queue: directed steps with a scoreboard of expected write-port records.
module tb_write_queue;
    import write_queue_pkg::*;

    localparam int DEPTH = 4;
`ifdef WRITE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic                     live;
        logic [LEN_CONTEXT-1:0]   ctx;
        logic [LEN_PREG_ADDR-1:0] pa;
        logic [LEN_WORD-1:0]      d;
    } ent_t;

    logic                     clk;
    logic                     rstn;
    logic                     alu_valid, mem_valid, alu_ready, mem_ready;
    logic [LEN_PREG_ADDR-1:0] alu_pa_rd, mem_pa_rd;
    logic [LEN_WORD-1:0]      alu_d, mem_d;
    logic [LEN_CONTEXT-1:0]   alu_context, mem_context, hazard_context_info;
    logic                     branch_hazard;
    logic [LEN_WRITE_D_R-1:0] w_write_d_r;

    ent_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    write_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .alu_valid           (alu_valid),
        .alu_pa_rd           (alu_pa_rd),
        .alu_d               (alu_d),
        .alu_context         (alu_context),
        .alu_ready           (alu_ready),
        .mem_valid           (mem_valid),
        .mem_pa_rd           (mem_pa_rd),
        .mem_d               (mem_d),
        .mem_context         (mem_context),
        .mem_ready           (mem_ready),
        .branch_hazard       (branch_hazard),
        .hazard_context_info (hazard_context_info),
        .w_write_d_r         (w_write_d_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic kill_m(input logic [LEN_CONTEXT-1:0] c, input logic hz,
                                    input logic [LEN_CONTEXT-1:0] m);
        return hz && (c != 4'b0000) && ((c & m) != 4'b0000);
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, expv);
        end
    endtask

    // One cycle: drive, compare against the model, update the model, advance the clock.
    task automatic step(input string tag,
                        input logic mv, input logic [5:0] mpa, input logic [31:0] md,
                        input logic [3:0] mctx,
                        input logic av, input logic [5:0] apa, input logic [31:0] ad,
                        input logic [3:0] actx,
                        input logic hz, input logic [3:0] hm);
        int cnt;
        logic exp_mr, exp_ar, mfwd, afwd;
        logic [LEN_WRITE_D_R-1:0] exp_out;
        ent_t e;
        mem_valid = mv; mem_pa_rd = mpa; mem_d = md; mem_context = mctx;
        alu_valid = av; alu_pa_rd = apa; alu_d = ad; alu_context = actx;
        branch_hazard = hz; hazard_context_info = hm;
        #1;
        cnt    = exp_q.size();
        exp_mr = (cnt <= DEPTH - 1);
        exp_ar = (cnt <= DEPTH - 2) || ((cnt == DEPTH - 1) && !mv);
        mfwd   = BYP && (cnt == 0) && mv && (mpa != 6'd0) && !kill_m(mctx, hz, hm);
        afwd   = BYP && (cnt == 0) && av && (apa != 6'd0) && !kill_m(actx, hz, hm) && !mv;
        if (cnt != 0)
            exp_out = {exp_q[0].live & ~kill_m(exp_q[0].ctx, hz, hm), exp_q[0].pa, exp_q[0].d};
        else if (mfwd)
            exp_out = {1'b1, mpa, md};
        else if (afwd)
            exp_out = {1'b1, apa, ad};
        else
            exp_out = {LEN_WRITE_D_R{1'b0}};
        check(tag, "w_write_d_r", 64'(w_write_d_r), 64'(exp_out));
        check(tag, "mem_ready", 64'(mem_ready), 64'(exp_mr));
        check(tag, "alu_ready", 64'(alu_ready), 64'(exp_ar));
        if (cnt != 0) void'(exp_q.pop_front());
        foreach (exp_q[i]) if (kill_m(exp_q[i].ctx, hz, hm)) exp_q[i].live = 1'b0;
        if (mv && exp_mr && (mpa != 6'd0) && !mfwd) begin
            e.live = !kill_m(mctx, hz, hm); e.ctx = mctx; e.pa = mpa; e.d = md;
            exp_q.push_back(e);
        end
        if (av && exp_ar && (apa != 6'd0) && !afwd) begin
            e.live = !kill_m(actx, hz, hm); e.ctx = actx; e.pa = apa; e.d = ad;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 6'd0, 32'd0, 4'd0, 1'b0, 6'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    initial begin
        rstn = 1'b0;
        mem_valid = 1'b1; mem_pa_rd = 6'd9; mem_d = 32'hDEAD; mem_context = 4'd0;
        alu_valid = 1'b1; alu_pa_rd = 6'd8; alu_d = 32'hBEEF; alu_context = 4'd0;
        branch_hazard = 1'b0; hazard_context_info = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "w_write_d_r", 64'(w_write_d_r), 64'd0);
        check("reset", "mem_ready", 64'(mem_ready), 64'd1);
        check("reset", "alu_ready", 64'(alu_ready), 64'd1);
        rstn = 1'b1;
        idle("post_reset");
        idle("post_reset2");

        // Single ALU request, then empty.
        step("alu_single", 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd5, 32'h1234, 4'd0, 1'b0, 4'd0);
        idle("alu_single_out");
        idle("alu_single_empty");

        // Both requests at once: mem first, then ALU.
        step("both", 1'b1, 6'd3, 32'hA, 4'd0, 1'b1, 6'd4, 32'hB, 4'd0, 1'b0, 4'd0);
        idle("both_out1");
        idle("both_out2");
        idle("both_empty");

        // p0 destinations are accepted but never written.
        step("drop_p0", 1'b1, 6'd0, 32'h55, 4'd0, 1'b1, 6'd0, 32'h66, 4'd0, 1'b0, 4'd0);
        idle("drop_p0_out");

        // Fill to count 3, then both at count 3 (ALU refused), then drain with wrap.
        step("fill1", 1'b1, 6'd10, 32'h10, 4'd0, 1'b1, 6'd11, 32'h11, 4'd0, 1'b0, 4'd0);
        step("fill2", 1'b1, 6'd12, 32'h12, 4'd0, 1'b1, 6'd13, 32'h13, 4'd0, 1'b0, 4'd0);
        step("full_both", 1'b1, 6'd14, 32'h14, 4'd0, 1'b1, 6'd15, 32'h15, 4'd0, 1'b0, 4'd0);
        step("full_alu", 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd16, 32'h16, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) idle("drain");

        // Hazard kill: contexts 01, 10, 00 then mask 10.
        step("hz_q1", 1'b1, 6'd20, 32'h20, 4'b0001, 1'b1, 6'd21, 32'h21, 4'b0010, 1'b0, 4'd0);
        step("hz_kill", 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd22, 32'h22, 4'b0000, 1'b1, 4'b0010);
        for (int i = 0; i < 3; i++) idle("hz_out");

        // Context zero survives an all-ones mask; incoming overlapping request enqueues dead.
        step("hz2_q", 1'b1, 6'd23, 32'h23, 4'b0000, 1'b1, 6'd24, 32'h24, 4'b0100, 1'b0, 4'd0);
        step("hz2_kill", 1'b1, 6'd25, 32'h25, 4'b1000, 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) idle("hz2_out");

        // Reset with three entries queued discards them all.
        step("rst_q1", 1'b1, 6'd30, 32'h30, 4'd0, 1'b1, 6'd31, 32'h31, 4'd0, 1'b0, 4'd0);
        mem_valid = 1'b1; mem_pa_rd = 6'd32; mem_d = 32'h32; mem_context = 4'd0;
        alu_valid = 1'b1; alu_pa_rd = 6'd33; alu_d = 32'h33; alu_context = 4'd0;
        @(posedge clk); #1;
        rstn = 1'b0;
        mem_pa_rd = 6'd34;
        #1;
        check("rst_mid", "w_write_d_r", 64'(w_write_d_r), 64'd0);
        check("rst_mid", "mem_ready", 64'(mem_ready), 64'd1);
        check("rst_mid", "alu_ready", 64'(alu_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_hold", "w_write_d_r", 64'(w_write_d_r), 64'd0);
        rstn = 1'b1;
        idle("rst_after1");
        idle("rst_after2");
        step("rst_new", 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd40, 32'h40, 4'd0, 1'b0, 4'd0);
        idle("rst_new_out");
        idle("rst_new_empty");

        // Empty-queue ALU request pa 7 (forwarded when bypass is built in).
        step("byp_alu", 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd7, 32'h77, 4'd0, 1'b0, 4'd0);
        idle("byp_after");
        idle("byp_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
